dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Multi-cycle sequencer between the core's load/store path and a data memory bus with variable latency and a valid/ready handshake.
- Accepts one decoded load/store per instruction and stalls the PC and register write-back until the access completes.
- Generates byte strobes and aligned store data, and sign- or zero-extends load data.
- Reports misaligned, bus-error and timeout faults.

Parameters:
- TIMEOUT, 255: maximum cycles in BUS before abort; legal range 1..65535.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- req  in  1  current instruction is a load or store
- mem_rw  in  1  MEM_READ (0) or MEM_WRITE (1), from the control decoder
- funct3  in  3  inst[14:12]: LB/LH/LW/LBU/LHU for loads, SB/SH/SW for stores
- addr  in  32  ALU result, the effective address
- wdata  in  32  rs2 value
- stall  out  1  hold PC and suppress reg_wr_en
- done  out  1  one-cycle pulse when the access completed without fault
- rdata  out  32  extended load data, valid while done=1
- fault  out  1  one-cycle pulse when the access aborted
- fault_cause  out  2  01 misaligned, 10 bus error, 11 timeout; 00 otherwise
- bus_valid  out  1  request valid
- bus_we  out  1  write enable
- bus_addr  out  32  {addr[31:2], 2'b00}
- bus_wstrb  out  4  byte strobes; 0000 for reads
- bus_wdata  out  32  lane-aligned store data
- bus_ready  in  1  bus accepts or completes the transfer this cycle
- bus_rdata  in  32  read data, valid with bus_ready
- bus_err  in  1  error response, valid with bus_ready

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE, bus_valid=0, done=0, fault=0, fault_cause=00, rdata=0, counter=0, all latched registers cleared.
- State IDLE:
  - req=1 with an aligned access: latch addr, funct3, mem_rw and aligned wdata/wstrb; go to BUS.
  - Aligned means halfword needs addr[0]=0 and word needs addr[1:0]=00.
  - req=1 with a misaligned access: go to ERR with cause 01; no bus request is issued.
  - stall = req in IDLE (combinational).
- State BUS:
  - bus_valid=1, and all bus outputs are held stable until bus_ready.
  - stall=1; the counter increments each cycle.
  - bus_ready=1 and bus_err=0: capture the extended read data into rdata and go to DONE.
  - bus_ready=1 and bus_err=1: go to ERR with cause 10.
  - bus_ready=0 and counter==TIMEOUT-1: drop bus_valid on the next edge and go to ERR with cause 11.
  - A bus_ready arriving in the same cycle as the timeout wins over the timeout.
- State DONE: done=1, stall=0, and the state returns to IDLE unconditionally. req is ignored in DONE because it still belongs to the completing instruction.
- State ERR: fault=1, cause is held, stall=0, and the state returns to IDLE unconditionally. rdata is not updated.
- Minimum latency is 3 cycles per memory instruction (IDLE, BUS with ready, DONE). Non-memory instructions see no stall.
- Store alignment:
  - SB: wstrb = 0001 shifted left by addr[1:0]; wdata = byte replicated on all 4 lanes.
  - SH: wstrb = 0011 or 1100 selected by addr[1]; wdata = halfword replicated on both halves.
  - SW: wstrb = 1111.
- Load extension:
  - The byte or halfword is selected by the latched addr[1:0].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
  - An unknown funct3 is treated as LW or SW.
- The counter is cleared on entry to BUS.
- Reset asserted mid-transaction aborts silently with no fault pulse. A late bus_ready after an abort is ignored in IDLE.

Decomposition:
- Shared header param.v holds:
  - funct3 load/store encodings and MEM_READ/MEM_WRITE;
  - state encodings DMC_IDLE/DMC_BUS/DMC_DONE/DMC_ERR;
  - fault cause codes FLT_NONE/FLT_MISALIGN/FLT_BUSERR/FLT_TIMEOUT.
- One combinational sub-module, dmem_align: inputs funct3, addr[1:0], wdata and bus_rdata; outputs wstrb, aligned wdata and extended rdata. The FSM, timeout counter and latches stay in dmem_access_ctrl.

Test Plan:
- LW addr=0x100, bus_ready in the first BUS cycle, bus_rdata=0xDEADBEEF -> bus_addr=0x100, wstrb=0000; DONE pulse 2 cycles after req; rdata=0xDEADBEEF; stall high for exactly 2 cycles.
- SB addr=0x203, wdata=0x000000A5 -> wstrb=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x200; bus_valid and bus outputs stable across 3 wait cycles.
- LB addr=0x3, bus_rdata=0x80FFFFFF -> rdata=0xFFFFFF80; LBU at the same address -> rdata=0x00000080; LH addr=0x2, bus_rdata=0x7FFF0000 -> rdata=0x00007FFF.
- LW addr=0x102 -> no bus_valid; fault=1 with cause 01 one cycle after req; stall falls after that cycle.
- TIMEOUT=4, bus_ready held at 0 -> bus_valid for 4 cycles, then fault with cause 11; a separate run with bus_err=1 on ready -> cause 10 and rdata unchanged.
- rst pulsed during BUS -> bus_valid=0 immediately, no fault or done pulse; the next req is serviced normally.

Source files
------------

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared encodings for the data-memory access sequencer: funct3 codes,
// FSM states, fault causes and access-size decode helpers.
package dmem_access_ctrl_pkg;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    DMC_IDLE = 2'b00,
    DMC_BUS  = 2'b01,
    DMC_DONE = 2'b10,
    DMC_ERR  = 2'b11
  } dmc_state_e;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'b00,
    FLT_MISALIGN = 2'b01,
    FLT_BUSERR   = 2'b10,
    FLT_TIMEOUT  = 2'b11
  } flt_cause_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } acc_size_e;

  // Loads and stores decode funct3 differently; unknown codes fall back to a word.
  function automatic acc_size_e access_size(input logic rw, input logic [2:0] f3);
    acc_size_e sz;
    sz = SZ_WORD;
    if (rw == MEM_READ) begin
      case (f3)
        F3_LB, F3_LBU: sz = SZ_BYTE;
        F3_LH, F3_LHU: sz = SZ_HALF;
        default:       sz = SZ_WORD;
      endcase
    end else begin
      case (f3)
        F3_SB:   sz = SZ_BYTE;
        F3_SH:   sz = SZ_HALF;
        F3_SW:   sz = SZ_WORD;
        default: sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

  function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] a);
    logic mis;
    case (sz)
      SZ_HALF: mis = a[0];
      SZ_WORD: mis = |a;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Data-memory bus: request/write payload from the sequencer, ready/data/error
// response from the memory side.
interface dmem_access_ctrl_if;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_ready, bus_rdata, bus_err
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_ready, bus_rdata, bus_err
  );
endinterface

// File: rtl/dmem_align.sv
// Lane steering for stores (strobes + replicated data) and lane selection
// with sign/zero extension for loads. Purely combinational.
module dmem_align
  import dmem_access_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_al,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    wstrb    = 4'b1111;
    wdata_al = wdata;
    case (access_size(MEM_WRITE, funct3))
      SZ_BYTE: begin
        wstrb    = 4'b0001 << addr_lo;
        wdata_al = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        wstrb    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_al = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (addr_lo)
      2'b00:   byte_sel = bus_rdata[7:0];
      2'b01:   byte_sel = bus_rdata[15:8];
      2'b10:   byte_sel = bus_rdata[23:16];
      default: byte_sel = bus_rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    case (funct3)
      F3_LB:   rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  rdata_ext = {24'h0, byte_sel};
      F3_LH:   rdata_ext = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  rdata_ext = {16'h0, half_sel};
      default: rdata_ext = bus_rdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer: issues one bus transfer per memory instruction,
// stalls the core until it completes, and reports misalign/bus/timeout faults.
//
//   state    | meaning
//   IDLE     | waiting for req; misaligned req goes straight to ERR
//   BUS      | bus_valid held with stable payload until ready or timeout
//   DONE     | one-cycle done pulse, rdata valid
//   ERR      | one-cycle fault pulse with fault_cause
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                mem_rw,
  input  logic [2:0]          funct3,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic                stall,
  output logic                done,
  output logic [31:0]         rdata,
  output logic                fault,
  output logic [1:0]          fault_cause,
  dmem_access_ctrl_if.master  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  dmc_state_e       state_q, state_d;
  flt_cause_e       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [2:0]       funct3_q, funct3_d;
  logic             rw_q, rw_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [2:0]  al_funct3;
  logic [1:0]  al_addr;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        misaligned;

  // One aligner serves both phases: live inputs while latching in IDLE,
  // latched funct3/addr while extending the read response.
  assign al_funct3  = (state_q == DMC_IDLE) ? funct3    : funct3_q;
  assign al_addr    = (state_q == DMC_IDLE) ? addr[1:0] : addr_q[1:0];
  assign misaligned = is_misaligned(access_size(mem_rw, funct3), addr[1:0]);

  dmem_align u_align (
    .funct3    (al_funct3),
    .addr_lo   (al_addr),
    .wdata     (wdata),
    .bus_rdata (bus.bus_rdata),
    .wstrb     (al_wstrb),
    .wdata_al  (al_wdata),
    .rdata_ext (al_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DMC_IDLE;
      cause_q  <= FLT_NONE;
      cnt_q    <= '0;
      addr_q   <= '0;
      funct3_q <= '0;
      rw_q     <= MEM_READ;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      rw_q     <= rw_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    funct3_d    = funct3_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;
    stall       = 1'b0;
    done        = 1'b0;
    fault       = 1'b0;
    fault_cause = FLT_NONE;

    case (state_q)
      DMC_IDLE: begin
        stall = req;
        if (req) begin
          if (misaligned) begin
            state_d = DMC_ERR;
            cause_d = FLT_MISALIGN;
          end else begin
            state_d  = DMC_BUS;
            cnt_d    = '0;
            addr_d   = addr;
            funct3_d = funct3;
            rw_d     = mem_rw;
            wdata_d  = al_wdata;
            wstrb_d  = (mem_rw == MEM_WRITE) ? al_wstrb : 4'b0000;
          end
        end
      end
      DMC_BUS: begin
        stall = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        // A response in the final cycle still completes the access.
        if (bus.bus_ready) begin
          if (bus.bus_err) begin
            state_d = DMC_ERR;
            cause_d = FLT_BUSERR;
          end else begin
            state_d = DMC_DONE;
            rdata_d = al_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = DMC_ERR;
          cause_d = FLT_TIMEOUT;
        end
      end
      DMC_DONE: begin
        done    = 1'b1;
        state_d = DMC_IDLE;
      end
      DMC_ERR: begin
        fault       = 1'b1;
        fault_cause = cause_q;
        state_d     = DMC_IDLE;
      end
      default: state_d = DMC_IDLE;
    endcase
  end

  assign rdata         = rdata_q;
  assign bus.bus_valid = (state_q == DMC_BUS);
  assign bus.bus_we    = rw_q;
  assign bus.bus_addr  = {addr_q[31:2], 2'b00};
  assign bus.bus_wstrb = wstrb_q;
  assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: table of aligned loads/stores plus
// hand sequences for misalign, timeout, bus error and mid-transfer reset.
module tb_dmem_access_ctrl;
  import dmem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        mem_rw;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        fault;
  logic [1:0]  fault_cause;

  int total = 0;
  int bad   = 0;

  dmem_access_ctrl_if bus_if ();

  dmem_access_ctrl #(.TIMEOUT(4), .CNT_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .mem_rw      (mem_rw),
    .funct3      (funct3),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .done        (done),
    .rdata       (rdata),
    .fault       (fault),
    .fault_cause (fault_cause),
    .bus         (bus_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] brd;
    int          waits;
    logic [3:0]  ewstrb;
    logic [31:0] ewdata;
    logic [31:0] eaddr;
    logic [31:0] erdata;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_txn(input vec_t v, input string tag);
    @(posedge clk); #1;
    req = 1'b1; mem_rw = v.rw; funct3 = v.f3; addr = v.addr; wdata = v.wd;
    bus_if.bus_ready = 1'b0; bus_if.bus_err = 1'b0;
    @(negedge clk);
    chk({tag, ".stall_req"}, 32'(stall), 32'd1);
    chk({tag, ".valid_idle"}, 32'(bus_if.bus_valid), 32'd0);
    for (int w = 0; w <= v.waits; w++) begin
      @(posedge clk); #1;
      bus_if.bus_ready = (w == v.waits);
      bus_if.bus_rdata = v.brd;
      @(negedge clk);
      chk({tag, ".valid"}, 32'(bus_if.bus_valid), 32'd1);
      chk({tag, ".addr"}, bus_if.bus_addr, v.eaddr);
      chk({tag, ".wstrb"}, 32'(bus_if.bus_wstrb), 32'(v.ewstrb));
      chk({tag, ".we"}, 32'(bus_if.bus_we), 32'(v.rw));
      if (v.rw) chk({tag, ".wdata"}, bus_if.bus_wdata, v.ewdata);
      chk({tag, ".stall_bus"}, 32'(stall), 32'd1);
    end
    @(posedge clk); #1;
    bus_if.bus_ready = 1'b0; req = 1'b0;
    @(negedge clk);
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".stall_done"}, 32'(stall), 32'd0);
    chk({tag, ".fault"}, 32'(fault), 32'd0);
    chk({tag, ".valid_done"}, 32'(bus_if.bus_valid), 32'd0);
    if (!v.rw) chk({tag, ".rdata"}, rdata, v.erdata);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t lw_ref;
    //          rw    f3      addr          wd            brd           w  wstrb    ewdata        eaddr         erdata
    vecs[0]  = '{1'b0, F3_LW,  32'h00000100, 32'h0,        32'hDEADBEEF, 0, 4'b0000, 32'h0,        32'h00000100, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, F3_SB,  32'h00000203, 32'h000000A5, 32'h0,        3, 4'b1000, 32'hA5A5A5A5, 32'h00000200, 32'h0};
    vecs[2]  = '{1'b0, F3_LB,  32'h00000003, 32'h0,        32'h80FFFFFF, 0, 4'b0000, 32'h0,        32'h00000000, 32'hFFFFFF80};
    vecs[3]  = '{1'b0, F3_LBU, 32'h00000003, 32'h0,        32'h80FFFFFF, 1, 4'b0000, 32'h0,        32'h00000000, 32'h00000080};
    vecs[4]  = '{1'b0, F3_LH,  32'h00000002, 32'h0,        32'h7FFF0000, 0, 4'b0000, 32'h0,        32'h00000000, 32'h00007FFF};
    vecs[5]  = '{1'b1, F3_SH,  32'h00000102, 32'h1234ABCD, 32'h0,        0, 4'b1100, 32'hABCDABCD, 32'h00000100, 32'h0};
    vecs[6]  = '{1'b1, F3_SW,  32'h00000040, 32'hCAFEF00D, 32'h0,        2, 4'b1111, 32'hCAFEF00D, 32'h00000040, 32'h0};
    vecs[7]  = '{1'b0, F3_LHU, 32'h00000000, 32'h0,        32'h12348001, 0, 4'b0000, 32'h0,        32'h00000000, 32'h00008001};
    vecs[8]  = '{1'b0, F3_LH,  32'h00000000, 32'h0,        32'h12348001, 0, 4'b0000, 32'h0,        32'h00000000, 32'hFFFF8001};
    vecs[9]  = '{1'b0, F3_LB,  32'h00000001, 32'h0,        32'h00007F00, 0, 4'b0000, 32'h0,        32'h00000000, 32'h0000007F};
    vecs[10] = '{1'b1, F3_SB,  32'h00000201, 32'h12345677, 32'h0,        0, 4'b0010, 32'h77777777, 32'h00000200, 32'h0};
    vecs[11] = '{1'b0, 3'b011, 32'h00000008, 32'h0,        32'h11223344, 0, 4'b0000, 32'h0,        32'h00000008, 32'h11223344};

    rst = 1'b1; req = 1'b0; mem_rw = 1'b0; funct3 = 3'b0; addr = '0; wdata = '0;
    bus_if.bus_ready = 1'b0; bus_if.bus_rdata = '0; bus_if.bus_err = 1'b0;
    @(negedge clk);
    chk("rst.valid", 32'(bus_if.bus_valid), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.fault", 32'(fault), 32'd0);
    chk("rst.cause", 32'(fault_cause), 32'd0);
    chk("rst.rdata", rdata, 32'h0);
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.addr", bus_if.bus_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 12; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // Misaligned LW and SH: fault one cycle after req, no bus request.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      req = 1'b1;
      mem_rw = (k == 0) ? 1'b0 : 1'b1;
      funct3 = (k == 0) ? F3_LW : F3_SH;
      addr   = (k == 0) ? 32'h00000102 : 32'h00000201;
      @(negedge clk);
      chk("mis.stall", 32'(stall), 32'd1);
      chk("mis.valid0", 32'(bus_if.bus_valid), 32'd0);
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      chk("mis.fault", 32'(fault), 32'd1);
      chk("mis.cause", 32'(fault_cause), 32'b01);
      chk("mis.stall_err", 32'(stall), 32'd0);
      chk("mis.valid1", 32'(bus_if.bus_valid), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mis.fault_pulse", 32'(fault), 32'd0);
      chk("mis.cause_clr", 32'(fault_cause), 32'b00);
    end

    lw_ref = '{1'b0, F3_LW, 32'h00000010, 32'h0, 32'h5A5A1234, 0, 4'b0000, 32'h0, 32'h00000010, 32'h5A5A1234};
    do_txn(lw_ref, "ref");

    // Timeout: bus_valid for exactly 4 cycles, then cause 11.
    @(posedge clk); #1;
    req = 1'b1; mem_rw = 1'b0; funct3 = F3_LW; addr = 32'h00000020;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("to.valid%0d", c), 32'(bus_if.bus_valid), 32'd1);
      chk("to.fault_early", 32'(fault), 32'd0);
    end
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("to.valid_drop", 32'(bus_if.bus_valid), 32'd0);
    chk("to.fault", 32'(fault), 32'd1);
    chk("to.cause", 32'(fault_cause), 32'b11);
    chk("to.done", 32'(done), 32'd0);
    chk("to.rdata", rdata, 32'h5A5A1234);

    // Bus error on ready: cause 10, rdata untouched.
    @(posedge clk); #1;
    req = 1'b1; mem_rw = 1'b0; funct3 = F3_LW; addr = 32'h00000030;
    @(posedge clk); #1;
    bus_if.bus_ready = 1'b1; bus_if.bus_err = 1'b1; bus_if.bus_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus_if.bus_ready = 1'b0; bus_if.bus_err = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("be.fault", 32'(fault), 32'd1);
    chk("be.cause", 32'(fault_cause), 32'b10);
    chk("be.done", 32'(done), 32'd0);
    chk("be.rdata", rdata, 32'h5A5A1234);

    // Reset during BUS: immediate bus_valid drop, no pulses, late ready ignored.
    @(posedge clk); #1;
    req = 1'b1; mem_rw = 1'b0; funct3 = F3_LW; addr = 32'h00000300;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("rb.valid", 32'(bus_if.bus_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rb.valid_async", 32'(bus_if.bus_valid), 32'd0);
    chk("rb.stall_async", 32'(stall), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rb.fault", 32'(fault), 32'd0);
      chk("rb.done", 32'(done), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'h00000099;
    @(negedge clk);
    chk("rb.late_valid", 32'(bus_if.bus_valid), 32'd0);
    chk("rb.late_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    bus_if.bus_ready = 1'b0;
    @(negedge clk);
    chk("rb.late_done2", 32'(done), 32'd0);
    chk("rb.late_fault", 32'(fault), 32'd0);
    chk("rb.rdata_clr", rdata, 32'h0);
    do_txn(vecs[0], "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
